// File: rtl/risc_pkg.sv
// Shared RISC-V decode definitions: opcodes, one-hot format encoding, queue occupancy
// and immediate builders (64-bit results; callers keep the low XLEN bits).
package risc_pkg;

    localparam logic [6:0] OPCODE_LUI           = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC         = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL           = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR          = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH        = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD          = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE         = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM        = 7'b0010011;
    localparam logic [6:0] OPCODE_OP            = 7'b0110011;
    localparam logic [6:0] OPCODE_I_TYPE_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPCODE_I_TYPE_FENCE  = 7'b0001111;

    typedef enum logic [5:0] {
        FMT_NONE = 6'b000000,
        FMT_R    = 6'b000001,
        FMT_I    = 6'b000010,
        FMT_S    = 6'b000100,
        FMT_B    = 6'b001000,
        FMT_U    = 6'b010000,
        FMT_J    = 6'b100000
    } fmt_e;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    // Built at the widest legal XLEN so one definition serves both datapath widths.
    function automatic logic [63:0] imm_i(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [63:0] imm_s(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [63:0] imm_b(input logic [31:0] instr);
        return {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [63:0] imm_u(input logic [31:0] instr);
        return {{32{instr[31]}}, instr[31:12], 12'b0};
    endfunction

    function automatic logic [63:0] imm_j(input logic [31:0] instr);
        return {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [6:0]        out_opcode;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [XLEN-1:0]   out_imm;
    logic [5:0]        out_fmt;
    logic              out_illegal;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_illegal, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_illegal, count
    );
endinterface

// File: rtl/decode_fifo.sv
// Generic synchronous FIFO with flush; pointers wrap modulo DEPTH (power of two),
// no push-through when full.
module decode_fifo
    import risc_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [WIDTH-1:0]           push_data_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    occ_e             occ_s;
    logic             push_s;
    logic             pop_s;

    // Occupancy class and the handshakes it drives.
    always_comb begin
        if (count_q == {(PTR_W+1){1'b0}}) begin
            occ_s = OCC_EMPTY;
        end else if (count_q == FULL_CNT) begin
            occ_s = OCC_FULL;
        end else begin
            occ_s = OCC_PARTIAL;
        end
        push_ready_o = (occ_s != OCC_FULL);
        pop_valid_o  = (occ_s != OCC_EMPTY);
        push_s       = push_valid_i && push_ready_o;
        pop_s        = pop_valid_o && pop_ready_i;
    end

    // Pointer and occupancy next state; flush wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (PTR_W+1)'(1'b1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/decode_stage.sv
// Buffered RISC-V decode stage: decode_fifo holding {instr, pc} plus decode of the head entry.
// Optional illegal-instruction detection is enabled by defining DECODE_ILLEGAL_EN.
module decode_stage
    import risc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_stage_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WIDTH = 32 + XLEN;

    logic [WIDTH-1:0] head_s;
    logic             head_valid_s;
    logic             in_ready_s;
    logic [CNT_W-1:0] count_s;
    logic [31:0]      instr_s;
    logic [XLEN-1:0]  pc_s;
    fmt_e             raw_fmt_s;
    fmt_e             fmt_s;
    logic             illegal_s;
    logic [63:0]      imm64_s;

    decode_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .push_valid_i (bus.in_valid),
        .push_ready_o (in_ready_s),
        .push_data_i  ({bus.in_instr, bus.in_pc}),
        .pop_valid_o  (head_valid_s),
        .pop_ready_i  (bus.out_ready),
        .pop_data_o   (head_s),
        .count_o      (count_s)
    );

    assign instr_s = head_s[WIDTH-1:XLEN];
    assign pc_s    = head_s[XLEN-1:0];

    // Instruction format from the opcode alone.
    always_comb begin
        raw_fmt_s = FMT_NONE;
        case (instr_s[6:0])
            OPCODE_OP:                              raw_fmt_s = FMT_R;
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: raw_fmt_s = FMT_I;
            OPCODE_STORE:                           raw_fmt_s = FMT_S;
            OPCODE_BRANCH:                          raw_fmt_s = FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:               raw_fmt_s = FMT_U;
            OPCODE_JAL:                             raw_fmt_s = FMT_J;
            default:                                raw_fmt_s = FMT_NONE;
        endcase
    end

`ifdef DECODE_ILLEGAL_EN
    // Illegal: non-32-bit encoding, unmapped opcode, or reserved branch funct3.
    always_comb begin
        illegal_s = 1'b0;
        if ((instr_s[1:0] != 2'b11) || (raw_fmt_s == FMT_NONE) ||
            ((instr_s[6:0] == OPCODE_BRANCH) &&
             ((instr_s[14:12] == 3'b010) || (instr_s[14:12] == 3'b011)))) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
        fmt_s = illegal_s ? FMT_NONE : raw_fmt_s;
    end
`else
    assign illegal_s = 1'b0;
    assign fmt_s     = raw_fmt_s;
`endif

    // Immediate selected by format; R-type and unrecognised yield zero.
    always_comb begin
        imm64_s = 64'd0;
        case (fmt_s)
            FMT_I:   imm64_s = imm_i(instr_s);
            FMT_S:   imm64_s = imm_s(instr_s);
            FMT_B:   imm64_s = imm_b(instr_s);
            FMT_U:   imm64_s = imm_u(instr_s);
            FMT_J:   imm64_s = imm_j(instr_s);
            default: imm64_s = 64'd0;
        endcase
    end

    // Output gating keeps every field at zero while the queue is empty.
    always_comb begin
        bus.in_ready  = in_ready_s;
        bus.count     = count_s;
        bus.out_valid = head_valid_s;
        if (head_valid_s) begin
            bus.out_pc      = pc_s;
            bus.out_opcode  = instr_s[6:0];
            bus.out_rd      = instr_s[11:7];
            bus.out_rs1     = instr_s[19:15];
            bus.out_rs2     = instr_s[24:20];
            bus.out_funct3  = instr_s[14:12];
            bus.out_funct7  = instr_s[31:25];
            bus.out_imm     = imm64_s[XLEN-1:0];
            bus.out_fmt     = fmt_s;
            bus.out_illegal = illegal_s;
        end else begin
            bus.out_pc      = {XLEN{1'b0}};
            bus.out_opcode  = 7'd0;
            bus.out_rd      = 5'd0;
            bus.out_rs1     = 5'd0;
            bus.out_rs2     = 5'd0;
            bus.out_funct3  = 3'd0;
            bus.out_funct7  = 7'd0;
            bus.out_imm     = {XLEN{1'b0}};
            bus.out_fmt     = 6'd0;
            bus.out_illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage at XLEN=32 and XLEN=64, DEPTH=2.
module tb_decode_stage;
    import risc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .DEPTH(2)) bus32 ();
    decode_stage_if #(.XLEN(64), .DEPTH(2)) bus64 ();

    decode_stage #(.XLEN(32), .DEPTH(2)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));
    decode_stage #(.XLEN(64), .DEPTH(2)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push32(input logic [31:0] instr, input logic [31:0] pc);
        bus32.in_valid = 1'b1;
        bus32.in_instr = instr;
        bus32.in_pc    = pc;
        tick();
        bus32.in_valid = 1'b0;
    endtask

    task automatic pop32();
        bus32.out_ready = 1'b1;
        tick();
        bus32.out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_instr = 32'd0; bus32.in_pc = 32'd0; bus32.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_instr = 32'd0; bus64.in_pc = 64'd0; bus64.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst_in_ready",  64'(bus32.in_ready),  64'd1);
        check_eq("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check_eq("rst_count",     64'(bus32.count),     64'd0);
        check_eq("rst_imm",       64'(bus32.out_imm),   64'd0);
        check_eq("rst_fmt",       64'(bus32.out_fmt),   64'd0);

        // addi x1, x0, 5
        push32(32'h0050_0093, 32'h0000_0100);
        check_eq("i_valid", 64'(bus32.out_valid), 64'd1);
        check_eq("i_fmt",   64'(bus32.out_fmt),   64'(FMT_I));
        check_eq("i_rd",    64'(bus32.out_rd),    64'd1);
        check_eq("i_rs1",   64'(bus32.out_rs1),   64'd0);
        check_eq("i_imm",   64'(bus32.out_imm),   64'd5);
        check_eq("i_pc",    64'(bus32.out_pc),    64'h100);
        check_eq("i_count", 64'(bus32.count),     64'd1);
        pop32();
        check_eq("pop_valid", 64'(bus32.out_valid), 64'd0);
        check_eq("pop_rd_gated", 64'(bus32.out_rd), 64'd0);

        // sw x2, 8(x1) then beq x0, x0, -4
        push32(32'h0020_A423, 32'h0000_0104);
        push32(32'hFE00_0EE3, 32'h0000_0108);
        check_eq("full_count",    64'(bus32.count),    64'd2);
        check_eq("full_in_ready", 64'(bus32.in_ready), 64'd0);
        check_eq("s_fmt", 64'(bus32.out_fmt), 64'(FMT_S));
        check_eq("s_rs1", 64'(bus32.out_rs1), 64'd1);
        check_eq("s_rs2", 64'(bus32.out_rs2), 64'd2);
        check_eq("s_imm", 64'(bus32.out_imm), 64'd8);

        bus32.out_ready = 1'b1;
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = 32'h0070_0393;
        bus32.in_pc     = 32'h0000_0120;
        #1;
        check_eq("full_no_pushthru", 64'(bus32.in_ready), 64'd0);
        tick();
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b0;
        check_eq("after_pop_count", 64'(bus32.count),   64'd1);
        check_eq("b_fmt",           64'(bus32.out_fmt), 64'(FMT_B));
        check_eq("b_imm",           64'(bus32.out_imm), 64'hFFFF_FFFC);
        check_eq("b_pc",            64'(bus32.out_pc),  64'h108);

        push32(32'h00A0_0113, 32'h0000_010C);
        check_eq("refill_count", 64'(bus32.count), 64'd2);

        flush = 1'b1;
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = 32'h0010_0093;
        bus32.in_pc     = 32'h0000_0200;
        bus32.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b0;
        check_eq("flush_count", 64'(bus32.count),     64'd0);
        check_eq("flush_valid", 64'(bus32.out_valid), 64'd0);
        check_eq("flush_pc",    64'(bus32.out_pc),    64'd0);
        tick();
        check_eq("flush_word_absent", 64'(bus32.count), 64'd0);

        // addi x3, x0, 3 after flush
        push32(32'h0030_0193, 32'h0000_0300);
        check_eq("post_flush_rd",  64'(bus32.out_rd),  64'd3);
        check_eq("post_flush_imm", 64'(bus32.out_imm), 64'd3);
        check_eq("post_flush_pc",  64'(bus32.out_pc),  64'h300);
        pop32();

        // sub x3, x1, x2
        push32(32'h4020_81B3, 32'h0000_0310);
        check_eq("r_fmt",    64'(bus32.out_fmt),    64'(FMT_R));
        check_eq("r_funct7", 64'(bus32.out_funct7), 64'h20);
        check_eq("r_funct3", 64'(bus32.out_funct3), 64'd0);
        check_eq("r_rs2",    64'(bus32.out_rs2),    64'd2);
        check_eq("r_imm",    64'(bus32.out_imm),    64'd0);
        check_eq("r_opcode", 64'(bus32.out_opcode), 64'h33);

        // jal x1, 8 pushed while the R-type head is popped
        bus32.out_ready = 1'b1;
        push32(32'h0080_00EF, 32'h0000_0314);
        bus32.out_ready = 1'b0;
        check_eq("pushpop_count", 64'(bus32.count),   64'd1);
        check_eq("j_fmt",         64'(bus32.out_fmt), 64'(FMT_J));
        check_eq("j_imm",         64'(bus32.out_imm), 64'd8);
        check_eq("j_pc",          64'(bus32.out_pc),  64'h314);
        pop32();

        push32(32'h0000_0000, 32'h0000_0400);
        check_eq("ill_valid",   64'(bus32.out_valid),   64'd1);
        check_eq("ill_flag",    64'(bus32.out_illegal), 64'(ILL_EN));
        check_eq("ill_fmt",     64'(bus32.out_fmt),     64'd0);
        pop32();
        check_eq("ill_popped",  64'(bus32.count),       64'd0);

        // branch with reserved funct3 = 010
        push32(32'h0000_2063, 32'h0000_0404);
        check_eq("rsv_br_flag", 64'(bus32.out_illegal), 64'(ILL_EN));
        check_eq("rsv_br_fmt",  64'(bus32.out_fmt),     ILL_EN ? 64'd0 : 64'(FMT_B));
        pop32();

        push32(32'h0050_0093, 32'h0000_0500);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midrst_count",    64'(bus32.count),     64'd0);
        check_eq("midrst_valid",    64'(bus32.out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(bus32.in_ready),  64'd1);

        // lui x5, 0x80000 at XLEN=64
        bus64.in_valid = 1'b1;
        bus64.in_instr = 32'h8000_02B7;
        bus64.in_pc    = 64'h0000_0000_0000_1000;
        tick();
        bus64.in_valid = 1'b0;
        check_eq("u64_fmt", 64'(bus64.out_fmt), 64'(FMT_U));
        check_eq("u64_rd",  64'(bus64.out_rd),  64'd5);
        check_eq("u64_imm", bus64.out_imm,      64'hFFFF_FFFF_8000_0000);
        check_eq("u64_pc",  bus64.out_pc,       64'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
